// File: rtl/ptl_arb_pkg.sv
// rtl/ptl_arb_pkg.sv - shared widths and parameter legality helpers for the PTL link arbiter
// Contents:
//   ptl_id_w      : requester ID width for N requesters
//   ptl_cnt_w     : width of a down-counter that starts at max_val-1
//   ptl_params_ok : elaboration-time legality of N / MIN_GAP / LINK_LAT / ID_W
package ptl_arb_pkg;

    localparam int PTL_N_MIN = 2;
    localparam int PTL_N_MAX = 16;

    function automatic int ptl_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // A counter loaded with max_val-1 never needs more than clog2(max_val)
    // bits; keep at least one bit so MIN_GAP=1 still has a legal vector.
    function automatic int ptl_cnt_w(input int max_val);
        return (max_val <= 2) ? 1 : $clog2(max_val);
    endfunction

    function automatic bit ptl_params_ok(input int n, input int id_w,
                                         input int min_gap, input int link_lat);
        return (n >= PTL_N_MIN) && (n <= PTL_N_MAX) &&
               (id_w >= ptl_id_w(n)) &&
               (min_gap >= 1) && (link_lat >= 1);
    endfunction

endpackage

// File: rtl/ptl_flight_delay.sv
// rtl/ptl_flight_delay.sv - LINK_LAT-deep {valid,id} shift register modelling PTL flight time
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (clears every stage)
//   in_valid, in_id     : launched pulse and its source ID
//   out_valid, out_id   : the same pulse LINK_LAT cycles later
module ptl_flight_delay #(
    parameter int LINK_LAT = 4,
    parameter int ID_W     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id
);

    logic [LINK_LAT-1:0] vld_q;
    logic [ID_W-1:0]     id_q [LINK_LAT];

    // The line shifts every cycle regardless of what is launched, so pulses
    // in flight are never disturbed by later grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LINK_LAT; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            id_q[0]  <= in_id;
            for (int i = 1; i < LINK_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[LINK_LAT-1];
    assign out_id    = id_q[LINK_LAT-1];

endmodule

// File: rtl/ptl_link_arbiter.sv
// rtl/ptl_link_arbiter.sv - round-robin scheduler sharing one PTL driver/receiver link among N requesters
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req[N]              : single-cycle request pulses
//   pend[N]             : registered pending flags
//   ovf[N]              : one-cycle pulse when a request is dropped
//   ptl_din, tx_id      : one-cycle pulse to the PTL driver and its source ID (ID held between pulses)
//   arr_valid, arr_id   : arrival strobe LINK_LAT cycles after ptl_din, with its source ID
module ptl_link_arbiter
    import ptl_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int ID_W     = $clog2(N),
    parameter int MIN_GAP  = 3,
    parameter int LINK_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    pend,
    output logic [N-1:0]    ovf,
    output logic            ptl_din,
    output logic [ID_W-1:0] tx_id,
    output logic            arr_valid,
    output logic [ID_W-1:0] arr_id
);

    localparam int GAP_W = ptl_cnt_w(MIN_GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N - 1);

    if (!ptl_params_ok(N, ID_W, MIN_GAP, LINK_LAT)) begin : g_param_check
        $error("ptl_link_arbiter: illegal N/ID_W/MIN_GAP/LINK_LAT combination");
    end

    logic [ID_W-1:0]  rr_ptr;
    logic [GAP_W-1:0] gap_cnt;

    logic [N-1:0]     gnt;
    logic [ID_W-1:0]  win_id;
    logic             found;
    logic [ID_W-1:0]  rr_next;

    // Round-robin pick: first pass covers rr_ptr..N-1, second pass wraps to
    // 0..rr_ptr-1, so the search order is rr_ptr, rr_ptr+1, ... without any
    // modulo arithmetic on the index.
    always_comb begin
        gnt    = '0;
        win_id = '0;
        found  = 1'b0;
        if ((gap_cnt == '0) && (|pend)) begin
            for (int i = 0; i < N; i++) begin
                if (!found && pend[i] && (ID_W'(i) >= rr_ptr)) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    win_id = ID_W'(i);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!found && pend[i] && (ID_W'(i) < rr_ptr)) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    win_id = ID_W'(i);
                end
            end
        end
    end

    // Explicit wrap so a non-power-of-two N never lets the pointer escape
    // the valid requester range.
    always_comb begin
        rr_next = '0;
        if (win_id != LAST_ID) begin
            rr_next = win_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            ovf     <= '0;
            ptl_din <= 1'b0;
            tx_id   <= '0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
        end else begin
            // A request landing on a requester being granted this cycle is
            // kept as the new pending entry; landing on a still-waiting one
            // is dropped and flagged.
            pend    <= (pend & ~gnt) | req;
            ovf     <= req & pend & ~gnt;
            ptl_din <= found;
            if (found) begin
                tx_id   <= win_id;
                rr_ptr  <= rr_next;
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    ptl_flight_delay #(
        .LINK_LAT (LINK_LAT),
        .ID_W     (ID_W)
    ) u_flight (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ptl_din),
        .in_id     (tx_id),
        .out_valid (arr_valid),
        .out_id    (arr_id)
    );

endmodule

// File: doc/ptl_link_arbiter.md
Name: ptl_link_arbiter

Overview:
- Cycle-level scheduler that shares one passive-transmission-line driver/receiver link (drvPTL-class cell pair) among N requesters.
- Captures single-cycle pulse requests, grants the link round-robin, and enforces a minimum inter-pulse gap so consecutive SFQ pulses on the PTL never overlap.
- Models link flight time so the receive side sees an arrival strobe tagged with the source ID.
- Sits between requesting cell groups and the PTL driver input in the gate-level timing model.

Parameters:
- N, 4, number of requesters (2..16).
- ID_W, $clog2(N), width of requester ID.
- MIN_GAP, 3, minimum cycles between successive ptl_din pulses (>=1).
- LINK_LAT, 4, cycles from ptl_din to arr_valid, i.e. the PTL flight time quantised to clock cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  per-requester single-cycle request pulse.
- pend  out  N  registered pending flags, one per requester.
- ovf  out  N  registered one-cycle pulse: request dropped.
- ptl_din  out  1  registered one-cycle pulse to the PTL driver input.
- tx_id  out  ID_W  ID of the current ptl_din pulse; holds its last value otherwise.
- arr_valid  out  1  one-cycle pulse, LINK_LAT cycles after ptl_din.
- arr_id  out  ID_W  ID accompanying arr_valid.

Behaviour:
- Reset (async assert, sync deassert internally not required): pend=0, ovf=0, ptl_din=0, tx_id=0, arr_valid=0, arr_id=0, rr_ptr=0, gap_cnt=0, delay line cleared. Reset mid-flight discards all pending and in-flight pulses; no arr_valid follows.
- Pending capture: at each edge, pend[i] <= (pend[i] & ~gnt[i]) | req[i].
- Same-cycle events:
  - req[i] while pend[i]=1 and gnt[i]=1: pend[i] stays 1 (new request kept), ovf[i]=0.
  - req[i] while pend[i]=1 and gnt[i]=0: ovf[i]=1 next cycle, pend unchanged.
- Arbitration (combinational on registered state): eligible when gap_cnt==0 and |pend.
  - Winner is the first set pend bit searching upward from rr_ptr, wrapping N-1 -> 0.
  - gnt is one-hot or zero.
- On grant of k:
  - ptl_din<=1, tx_id<=k next edge.
  - rr_ptr <= (k+1) mod N; the wrap at N-1 is explicit for non-power-of-2 N.
  - gap_cnt <= MIN_GAP-1.
- Otherwise ptl_din<=0, and gap_cnt decrements to 0 (saturating).
- Spacing: successive ptl_din pulses are at least MIN_GAP cycles apart. With MIN_GAP=1, back-to-back pulses are allowed.
- Latency: req at edge t -> pend at t -> ptl_din high after edge t+1 (2-edge best case).
- Flight: a LINK_LAT-deep shift register of {valid,id}. arr_valid/arr_id at edge s+LINK_LAT equal ptl_din/tx_id at edge s. Delay continues regardless of new grants.
- No requests are ever lost except those flagged by ovf.

Decomposition:
- Package ptl_arb_pkg: ID width function and the minimum-legal parameter checks (MIN_GAP>=1, LINK_LAT>=1, N>=2) as elaboration-time constants/assertions.
- One sub-module: ptl_flight_delay (parameterised LINK_LAT shift register of {valid,id}, async active-low reset). The round-robin picker stays inline.

Test Plan (N=4, MIN_GAP=3, LINK_LAT=4):
- Reset then req=4'b0001 at edge 1 -> ptl_din pulse after edge 2, tx_id=0; arr_valid with arr_id=0 after edge 6; pend[0] clear after edge 2.
- req=4'b1111 at edge 1 -> ptl_din pulses after edges 2, 5, 8, 11 with tx_id 0, 1, 2, 3; no ovf; rr_ptr wraps to 0.
- Requester 2 pulses at edges 1 and 2 while requester 0 holds the link gap -> ovf[2] pulse after edge 2; exactly one tx_id=2 pulse.
- Requester 1 pulses in the same cycle it is granted -> pend[1] stays 1, second tx_id=1 pulse exactly MIN_GAP cycles later, ovf=0.
- rst_n low for one cycle between ptl_din and its arrival -> all outputs 0 immediately, no arr_valid afterwards, next req served with rr_ptr=0.
- MIN_GAP=1 rebuild with req=4'b1010 held each cycle -> ptl_din high every cycle, tx_id alternates 1, 3, 1, 3; arr stream identical, shifted 4 cycles.
